// File: rtl/sd_fifo_arbiter_pkg.sv
// Shared types and constants for the SD FIFO port arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2,
    ARB_TURN = 2'd3
  } arb_state_e;

  localparam int   NUM_CLIENTS = 2;
  localparam logic PICO_ID     = 1'b0;
  localparam logic FPGA_ID     = 1'b1;

  function automatic arb_state_e grant_state(input logic id);
    return (id == FPGA_ID) ? ARB_GNT1 : ARB_GNT0;
  endfunction

endpackage

// File: rtl/sd_fifo_arbiter_if.sv
// Client-side handshake and SD FIFO bus shared by the arbiter and its environment.
interface sd_fifo_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0, req1, gnt0, gnt1;
  logic             rd_en0, rd_en1, wr_en0, wr_en1;
  logic [7:0]       rd_dat0, rd_dat1, wr_dat0, wr_dat1;
  logic             rd_en, rd_empty, wr_en, wr_full;
  logic [7:0]       rd_dat, wr_dat;
  logic             fpga_mode, timeout_err, proto_err;
  logic [CNT_W-1:0] xfer_cnt;

  modport slave (
    input  req0, req1, rd_en0, rd_en1, wr_en0, wr_en1, wr_dat0, wr_dat1,
           rd_dat, rd_empty, wr_full,
    output gnt0, gnt1, rd_dat0, rd_dat1, rd_en, wr_en, wr_dat,
           fpga_mode, xfer_cnt, timeout_err, proto_err
  );

  modport master (
    output req0, req1, rd_en0, rd_en1, wr_en0, wr_en1, wr_dat0, wr_dat1,
           rd_dat, rd_empty, wr_full,
    input  gnt0, gnt1, rd_dat0, rd_dat1, rd_en, wr_en, wr_dat,
           fpga_mode, xfer_cnt, timeout_err, proto_err
  );
endinterface

// File: rtl/sd_fifo_arbiter_idle_timer.sv
// Idle down-counter: reloads on restart, expires after TIMEOUT_CYC idle owner cycles.
module sd_arb_idle_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic expire
);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // The cycle after a reload is already the first idle cycle, hence the minus one.
  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  logic [TMR_W-1:0] cnt_r;

  // Reload on restart, otherwise count down while an owner is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= LOAD_VAL;
    end else if (restart) begin
      cnt_r <= LOAD_VAL;
    end else if (active && (cnt_r != {TMR_W{1'b0}})) begin
      cnt_r <= cnt_r - TMR_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && active && !restart && (cnt_r == {TMR_W{1'b0}});

endmodule

// File: rtl/sd_fifo_arbiter.sv
// Dynamic PICO/FPGA arbiter for the SD-controller FIFO port: round-robin grant,
// one dead turnaround cycle, idle-timeout release, transfer counting and error flags.
module sd_fifo_arbiter
  import sd_arb_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic              clk,
  input logic              rst_n,
  sd_fifo_arbiter_if.slave bus
);

  arb_state_e             state_r, next_s;
  logic                   last_owner_r, pick_s;
  logic                   gnt0_r, gnt1_r, fpga_mode_r, timeout_err_r, proto_err_r;
  logic [CNT_W-1:0]       xfer_cnt_r;
  logic [NUM_CLIENTS-1:0] req_s;
  logic                   own0_s, own1_s, entry_s, expire_s, restart_s, timed_out_s, viol_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign req_s     = {bus.req1, bus.req0};
  assign own0_s    = (state_r == ARB_GNT0);
  assign own1_s    = (state_r == ARB_GNT1);
  assign entry_s   = (next_s != state_r) && ((next_s == ARB_GNT0) || (next_s == ARB_GNT1));
  assign restart_s = entry_s | bus.rd_en | bus.wr_en;
  assign viol_s    = ((bus.rd_en0 | bus.wr_en0) & ~gnt0_r) | ((bus.rd_en1 | bus.wr_en1) & ~gnt1_r);

  sd_arb_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (own0_s | own1_s),
    .restart (restart_s),
    .expire  (expire_s)
  );

  // Arbitration winner: contention alternates away from the previous owner
  always_comb begin
    pick_s = PICO_ID;
    if (req_s == 2'b11) begin
      pick_s = ~last_owner_r;
    end else if (req_s[FPGA_ID]) begin
      pick_s = FPGA_ID;
    end else begin
      pick_s = PICO_ID;
    end
  end

  // Next state; a dropped request wins over a simultaneous timeout
  always_comb begin
    next_s      = state_r;
    timed_out_s = 1'b0;
    case (state_r)
      ARB_IDLE, ARB_TURN: begin
        if (req_s != {NUM_CLIENTS{1'b0}}) begin
          next_s = grant_state(pick_s);
        end else begin
          next_s = ARB_IDLE;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (!(own0_s ? bus.req0 : bus.req1)) begin
          next_s = ARB_TURN;
        end else if (expire_s) begin
          next_s      = ARB_TURN;
          timed_out_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      default: next_s = ARB_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Grants, status, transfer counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_r        <= 1'b0;
      gnt1_r        <= 1'b0;
      fpga_mode_r   <= 1'b0;
      last_owner_r  <= FPGA_ID;
      xfer_cnt_r    <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
      proto_err_r   <= 1'b0;
    end else begin
      gnt0_r        <= (next_s == ARB_GNT0);
      gnt1_r        <= (next_s == ARB_GNT1);
      fpga_mode_r   <= (next_s == ARB_GNT1);
      timeout_err_r <= timeout_err_r | timed_out_s;
      proto_err_r   <= proto_err_r | viol_s;
      if (entry_s) begin
        last_owner_r <= (next_s == ARB_GNT1);
        xfer_cnt_r   <= {CNT_W{1'b0}};
      end else if (own0_s || own1_s) begin
        last_owner_r <= last_owner_r;
        xfer_cnt_r   <= sat_add(xfer_cnt_r, {1'b0, bus.rd_en} + {1'b0, bus.wr_en});
      end else begin
        last_owner_r <= last_owner_r;
        xfer_cnt_r   <= xfer_cnt_r;
      end
    end
  end

  // Owner-only FIFO strobe and write-data mux; blocked strobes are dropped
  always_comb begin
    bus.rd_en  = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_dat = 8'h00;
    if (own0_s) begin
      bus.rd_en  = bus.rd_en0 & ~bus.rd_empty;
      bus.wr_en  = bus.wr_en0 & ~bus.wr_full;
      bus.wr_dat = bus.wr_dat0;
    end else if (own1_s) begin
      bus.rd_en  = bus.rd_en1 & ~bus.rd_empty;
      bus.wr_en  = bus.wr_en1 & ~bus.wr_full;
      bus.wr_dat = bus.wr_dat1;
    end else begin
      bus.rd_en  = 1'b0;
      bus.wr_en  = 1'b0;
      bus.wr_dat = 8'h00;
    end
  end

  assign bus.rd_dat0     = bus.rd_dat;
  assign bus.rd_dat1     = bus.rd_dat;
  assign bus.gnt0        = gnt0_r;
  assign bus.gnt1        = gnt1_r;
  assign bus.fpga_mode   = fpga_mode_r;
  assign bus.xfer_cnt    = xfer_cnt_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.proto_err   = proto_err_r;

endmodule
